// File: rtl/single_cycle_cpu_top.sv
// Single-cycle RV32 subset core running a fixed 3x3 determinant program (result to data word 9).
// Optional build macro REG_RESET_EN: synchronous reset also clears x1..x31.

module data_memory #(
  parameter int XLEN       = 32,
  parameter int DMEM_DEPTH = 64
) (
  input  logic            clk,
  input  logic            we,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);
  localparam int AW = $clog2(DMEM_DEPTH);

  // Power-up contents: the 3x3 matrix a..i in row-major order; not touched by reset.
  reg [XLEN-1:0] D_Memory [0:DMEM_DEPTH-1] = '{0: 2, 1: -3, 2: 1,
                                               3: 2, 4: 0,  5: -1,
                                               6: 1, 7: 4,  8: 5,
                                               default: 0};

  logic [AW-1:0] idx;
  logic          unused_addr;

  assign idx         = address[AW+1:2];
  assign unused_addr = ^{address[XLEN-1:AW+2], address[1:0]};
  assign rdata       = D_Memory[idx];

  always @(posedge clk) begin
    if (we) D_Memory[idx] <= wdata;
  end
endmodule

module single_cycle_cpu_top #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] Rd2_top,
  output logic [XLEN-1:0] address_top,
  output logic            MemWrite_top
);
  localparam int PCW = $clog2(IMEM_DEPTH) + 2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_SUB   = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_t;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  logic [PCW-1:0]  pc;
  logic [PCW-1:0]  pc_next;
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm;
  logic [XLEN-1:0] rd1, rd2, alu_res, mem_rdata, wb_data;
  logic [XLEN-1:0] regs [0:31];
  logic            reg_write, mem_write, mem_to_reg, alu_src_imm, branch;
  alu_op_t         alu_op;
  logic            unused_bits;

  // Program: load a..i into x1..x9, form the 2x2 minors, expand along row 0, store to word 9.
  always_comb begin
    int idx;
    idx   = int'(pc[PCW-1:2]);
    instr = enc_i(12'd0, 5'd0, 3'b000, 5'd0, OP_IMM);
    if (idx < 9) begin
      instr = enc_i(12'(idx * 4), 5'd0, 3'b010, 5'(idx + 1), OP_LOAD);
    end else begin
      case (idx)
        9:  instr = enc_r(F7_MULDIV, 5'd9, 5'd5, 3'b000, 5'd10);
        10: instr = enc_r(F7_MULDIV, 5'd8, 5'd6, 3'b000, 5'd11);
        11: instr = enc_r(F7_MULDIV, 5'd9, 5'd4, 3'b000, 5'd12);
        12: instr = enc_r(F7_MULDIV, 5'd7, 5'd6, 3'b000, 5'd13);
        13: instr = enc_r(F7_MULDIV, 5'd8, 5'd4, 3'b000, 5'd14);
        14: instr = enc_r(F7_MULDIV, 5'd7, 5'd5, 3'b000, 5'd15);
        15: instr = enc_r(F7_SUB,    5'd11, 5'd10, 3'b000, 5'd10);
        16: instr = enc_r(F7_SUB,    5'd13, 5'd12, 3'b000, 5'd12);
        17: instr = enc_r(F7_SUB,    5'd15, 5'd14, 3'b000, 5'd14);
        18: instr = enc_r(F7_MULDIV, 5'd10, 5'd1, 3'b000, 5'd10);
        19: instr = enc_r(F7_MULDIV, 5'd12, 5'd2, 3'b000, 5'd12);
        20: instr = enc_r(F7_MULDIV, 5'd14, 5'd3, 3'b000, 5'd14);
        21: instr = enc_r(F7_SUB,    5'd12, 5'd10, 3'b000, 5'd10);
        22: instr = enc_r(F7_BASE,   5'd14, 5'd10, 3'b000, 5'd10);
        23: instr = enc_s(12'd36, 5'd10, 5'd0);
        24: instr = enc_beq(13'd0, 5'd0, 5'd0);
        default: ;
      endcase
    end
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_imm = 1'b0;
    branch      = 1'b0;
    alu_op      = ALU_ADD;
    imm         = imm_i;
    case (opcode)
      OP_LOAD: begin
        reg_write   = 1'b1;
        mem_to_reg  = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_STORE: begin
        mem_write   = 1'b1;
        alu_src_imm = 1'b1;
        imm         = imm_s;
      end
      OP_IMM: begin
        reg_write   = (funct3 == 3'b000);
        alu_src_imm = 1'b1;
      end
      OP_BRANCH: branch = (funct3 == 3'b000);
      OP_REG: begin
        reg_write = 1'b1;
        case ({funct7, funct3})
          {F7_BASE,   3'b000}: alu_op = ALU_ADD;
          {F7_SUB,    3'b000}: alu_op = ALU_SUB;
          {F7_BASE,   3'b111}: alu_op = ALU_AND;
          {F7_BASE,   3'b110}: alu_op = ALU_OR;
          {F7_BASE,   3'b010}: alu_op = ALU_SLT;
          {F7_MULDIV, 3'b000}: alu_op = ALU_MUL;
          default:             reg_write = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign rd1 = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rd2 = (rs2 == 5'd0) ? '0 : regs[rs2];

  always_comb begin
    logic signed [XLEN-1:0] src_a, src_b;
    src_a   = rd1;
    src_b   = alu_src_imm ? imm : rd2;
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_MUL: alu_res = src_a * src_b;
      default: alu_res = '0;
    endcase
  end

  data_memory #(.XLEN(XLEN), .DMEM_DEPTH(DMEM_DEPTH)) Data_Memory (
    .clk     (clk),
    .we      (mem_write),
    .address (alu_res),
    .wdata   (rd2),
    .rdata   (mem_rdata)
  );

  assign wb_data = mem_to_reg ? mem_rdata : alu_res;

`ifdef REG_RESET_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k < 32; k++) regs[k] <= '0;
    end else if (reg_write && rd != 5'd0) begin
      regs[rd] <= wb_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reg_write && rd != 5'd0) regs[rd] <= wb_data;
  end
`endif

  // PC width spans exactly the ROM byte range, so the +4 and branch adds wrap naturally.
  assign pc_next = (branch && rd1 == rd2) ? pc + imm_b[PCW-1:0] : pc + PCW'(4);

  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end

  assign unused_bits  = ^{pc[1:0], imm_b[XLEN-1:PCW]};
  assign Rd2_top      = rd2;
  assign address_top  = alu_res;
  assign MemWrite_top = mem_write;
endmodule

// File: tb/tb_single_cycle_cpu_top.sv
// Bench for single_cycle_cpu_top: random and fixed matrices checked against a determinant model.
module tb_single_cycle_cpu_top;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Rd2_top, address_top;
  logic        MemWrite_top;
  int          total = 0;
  int          bad = 0;

  int          mat [9];
  int          st_cnt, st_cycle;
  logic [31:0] st_addr, st_data;

  single_cycle_cpu_top dut (
    .clk          (clk),
    .reset        (reset),
    .Rd2_top      (Rd2_top),
    .address_top  (address_top),
    .MemWrite_top (MemWrite_top)
  );

  always #5 clk = ~clk;

  // Cofactor expansion along the first row, in 32-bit wrapping arithmetic.
  function automatic int ref_det();
    return mat[0] * (mat[4] * mat[8] - mat[5] * mat[7])
         - mat[1] * (mat[3] * mat[8] - mat[5] * mat[6])
         + mat[2] * (mat[3] * mat[7] - mat[4] * mat[6]);
  endfunction

  task automatic load_matrix();
    for (int i = 0; i < 9; i++) dut.Data_Memory.D_Memory[i] = mat[i];
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs n cycles numbered from 1, recording every store seen.
  task automatic run(input int n);
    st_cnt = 0; st_cycle = 0; st_addr = '0; st_data = '0;
    for (int k = 1; k <= n; k++) begin
      #1;
      if (MemWrite_top !== 1'b0) begin
        st_cnt++;
        if (st_cnt == 1) begin
          st_cycle = k; st_addr = address_top; st_data = Rd2_top;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (dut.pc !== '0) begin bad++; $display("FAIL reset_pc: got %0d want 0", dut.pc); end
    total++; if (MemWrite_top !== 1'b0) begin bad++; $display("FAIL reset_memwrite: got %b want 0", MemWrite_top); end
    total++; if (address_top !== 32'h0) begin bad++; $display("FAIL reset_address: got %h want 00000000", address_top); end
    total++; if (Rd2_top !== 32'h0) begin bad++; $display("FAIL reset_rd2: got %h want 00000000", Rd2_top); end
    @(posedge clk); #1;
    total++; if (dut.pc !== '0) begin bad++; $display("FAIL reset_hold_pc: got %0d want 0", dut.pc); end
  endtask

  task automatic test_default();
    int init_vals [9] = '{2, -3, 1, 2, 0, -1, 1, 4, 5};
    int nbad = 0;
    for (int i = 0; i < 9; i++)
      if (dut.Data_Memory.D_Memory[i] !== 32'(init_vals[i])) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL init_matrix: got %0d wrong words want 0", nbad); end
    total++; if (dut.Data_Memory.D_Memory[9] !== 32'h0) begin bad++; $display("FAIL init_word9: got %h want 0", dut.Data_Memory.D_Memory[9]); end
    mat = init_vals;
    pulse_reset(2);
    run(25);
    total++; if (st_cnt != 1) begin bad++; $display("FAIL default_store_count: got %0d want 1", st_cnt); end
    total++; if (st_cycle != 24) begin bad++; $display("FAIL default_store_cycle: got %0d want 24", st_cycle); end
    total++; if (st_addr !== 32'h24) begin bad++; $display("FAIL default_store_addr: got %h want 00000024", st_addr); end
    total++; if (st_data !== 32'h31) begin bad++; $display("FAIL default_store_data: got %h want 00000031", st_data); end
    total++; if (dut.Data_Memory.D_Memory[9] !== 32'd49) begin bad++; $display("FAIL default_word9: got %0d want 49", dut.Data_Memory.D_Memory[9]); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int exp;
      for (int i = 0; i < 9; i++)
        mat[i] = (t < 4) ? int'($urandom_range(0, 40)) - 20 : int'($urandom);
      exp = ref_det();
      load_matrix();
      dut.Data_Memory.D_Memory[9] = 32'hDEAD_BEEF;
      pulse_reset(2);
      run(25);
      total++; if (st_cnt != 1 || st_cycle != 24 || st_addr !== 32'h24) begin
        bad++; $display("FAIL random_store_%0d: got count=%0d cycle=%0d addr=%h want 1/24/00000024", t, st_cnt, st_cycle, st_addr);
      end
      total++; if (dut.Data_Memory.D_Memory[9] !== 32'(exp)) begin
        bad++; $display("FAIL random_det_%0d: got %0d want %0d", t, $signed(dut.Data_Memory.D_Memory[9]), exp);
      end
    end
  endtask

  task automatic test_special();
    int ident [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int rows  [9] = '{3, -7, 11, 3, -7, 11, 3, -7, 11};
    int want  [2] = '{1, 0};
    for (int t = 0; t < 2; t++) begin
      mat = (t == 0) ? ident : rows;
      load_matrix();
      dut.Data_Memory.D_Memory[9] = 32'h1234_5678;
      pulse_reset(2);
      run(25);
      total++; if (dut.Data_Memory.D_Memory[9] !== 32'(want[t]) || 32'(ref_det()) !== 32'(want[t])) begin
        bad++; $display("FAIL special_det_%0d: got %0d want %0d", t, $signed(dut.Data_Memory.D_Memory[9]), want[t]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int base [9] = '{2, -3, 1, 2, 0, -1, 1, 4, 5};
    mat = base;
    load_matrix();
    dut.Data_Memory.D_Memory[9] = 32'hDEAD_BEEF;
    pulse_reset(2);
    run(9);
    total++; if (st_cnt != 0) begin bad++; $display("FAIL midreset_prefix_stores: got %0d want 0", st_cnt); end
    pulse_reset(1);
    run(25);
    total++; if (st_cnt != 1 || st_cycle != 24) begin
      bad++; $display("FAIL midreset_store: got count=%0d cycle=%0d want 1/24", st_cnt, st_cycle);
    end
    total++; if (dut.Data_Memory.D_Memory[9] !== 32'(ref_det())) begin
      bad++; $display("FAIL midreset_word9: got %0d want %0d", $signed(dut.Data_Memory.D_Memory[9]), ref_det());
    end
  endtask

  task automatic test_halt();
    logic [31:0] snap [64];
    int nbad = 0;
    for (int i = 0; i < 64; i++) snap[i] = dut.Data_Memory.D_Memory[i];
    run(20);
    total++; if (st_cnt != 0) begin bad++; $display("FAIL halt_stores: got %0d want 0", st_cnt); end
    for (int i = 0; i < 64; i++) if (dut.Data_Memory.D_Memory[i] !== snap[i]) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL halt_memory: got %0d changed words want 0", nbad); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_random();
    test_special();
    test_mid_reset();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
